// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream_mux_nx1 family (N:1 registered stream mux).
package stream_mux_pkg;

    typedef enum logic {MODE_FIXED, MODE_RR} mode_e;

    // Index width for a channel count; a single channel still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_if.sv
// Bundle of N producer streams, the select controls and the single consumer stream.
interface stream_mux_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8
) ();
    localparam int SEL_W = stream_mux_pkg::idx_width(CHANNELS);

    // valid/ready: a word moves on a rising clk edge where both valid and ready
    // are high; a producer holds valid and data stable until that edge.
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [SEL_W-1:0]          sel;
    logic                      rr_mode;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          out_chan;

    modport master (
        output in_data, in_valid, sel, rr_mode, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );

    modport slave (
        input  in_data, in_valid, sel, rr_mode, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester after ptr, wrapping modulo CHANNELS.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int  CHANNELS = 8,
    localparam int SEL_W    = idx_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    gnt_idx,
    output logic                gnt_any
);

    int idx;

    // Searching ptr+1 .. ptr+CHANNELS makes ptr itself the lowest priority.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!gnt_any && req[SEL_W'(idx)]) begin
                gnt_any = 1'b1;
                gnt_idx = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_mux_nx1.sv
// N:1 stream mux with one output register stage; round-robin arbitration is
// compiled in only when STREAM_MUX_RR_EN is defined, otherwise fixed sel always applies.
module stream_mux_nx1
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8
) (
    input  logic        clk,
    input  logic        rst,
    stream_mux_if.slave bus
);

    localparam int              SEL_W    = idx_width(CHANNELS);
    localparam logic [0:0]      ST_EMPTY = 1'b0;
    localparam logic [0:0]      ST_FULL  = 1'b1;
    localparam logic [SEL_W:0]  CHAN_LIM = (SEL_W + 1)'(CHANNELS);

    logic [0:0]          state_q, state_d;
    logic [WIDTH-1:0]    data_q, data_d, sel_data;
    logic [SEL_W-1:0]    chan_q, chan_d, gnt_idx;
    logic                gnt_any, load_ok, accept, xfer_out;
    logic [CHANNELS-1:0] ready;

`ifdef STREAM_MUX_RR_EN
    mode_e            mode;
    logic [SEL_W-1:0] ptr_q, ptr_d, rr_idx;
    logic             rr_any;

    rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .req     (bus.in_valid),
        .ptr     (ptr_q),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    assign mode = bus.rr_mode ? MODE_RR : MODE_FIXED;
`else
    logic rr_mode_unused;
    assign rr_mode_unused = bus.rr_mode;
`endif

    // Fixed mode grants sel even when that channel is idle; out-of-range sel grants nothing.
    always_comb begin
        gnt_idx = bus.sel;
        gnt_any = ({1'b0, bus.sel} < CHAN_LIM);
`ifdef STREAM_MUX_RR_EN
        if (mode == MODE_RR) begin
            gnt_idx = rr_idx;
            gnt_any = rr_any;
        end
`endif
    end

    assign load_ok  = (state_q == ST_EMPTY) || bus.out_ready;
    assign xfer_out = (state_q == ST_FULL) && bus.out_ready;

    // in_ready never depends on in_data; only the captured word does.
    always_comb begin
        ready    = '0;
        sel_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (gnt_idx == SEL_W'(k)) begin
                ready[k] = gnt_any && load_ok && !rst;
                sel_data = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = |(ready & bus.in_valid);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        chan_d  = chan_q;
        if (accept) begin
            state_d = ST_FULL;
            data_d  = sel_data;
            chan_d  = gnt_idx;
        end else if (xfer_out) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
        end
    end

`ifdef STREAM_MUX_RR_EN
    // Reset ptr to the last channel so the first search begins at channel 0.
    assign ptr_d = (accept && mode == MODE_RR) ? gnt_idx : ptr_q;

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= SEL_W'(CHANNELS - 1);
        else     ptr_q <= ptr_d;
    end
`endif

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Directed, table-driven bench for stream_mux_nx1 (8-channel and 6-channel instances).
module tb_stream_mux_nx1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_mux_if #(.WIDTH(8), .CHANNELS(8)) if8 ();
  stream_mux_if #(.WIDTH(8), .CHANNELS(6)) if6 ();

  stream_mux_nx1 #(.WIDTH(8), .CHANNELS(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  stream_mux_nx1 #(.WIDTH(8), .CHANNELS(6)) u_dut6 (
    .clk (clk),
    .rst (rst),
    .bus (if6.slave)
  );

  typedef struct {
    logic [7:0]  valid;
    logic [2:0]  sel;
    logic        rr;
    logic        ordy;
    logic [63:0] data;
    logic [7:0]  exp_rdy;
    logic        exp_vld;
    logic [7:0]  exp_data;
    logic [2:0]  exp_chan;
  } vec_t;

  // Channel k data sits in byte k; D0 puts 8'hF1 on channel 5.
  localparam logic [63:0] D0 = 64'hA7A6_F1A4_A3A2_A1A0;
  localparam logic [63:0] D1 = 64'h0102_0304_0506_0708;
  localparam logic [63:0] DK = 64'h0706_0504_0302_0100;

  vec_t tbl[11];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    end
  endtask

  task automatic drive8(input logic [7:0] v, input logic [2:0] s, input logic rr,
                        input logic ordy, input logic [63:0] d);
    if8.in_valid  = v;
    if8.sel       = s;
    if8.rr_mode   = rr;
    if8.out_ready = ordy;
    if8.in_data   = d;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step(input string tag, input logic [7:0] exp_rdy, input logic exp_vld,
                      input logic [7:0] exp_data, input logic [2:0] exp_chan);
    #1;
    check({tag, " in_ready"}, 64'(if8.in_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
    check({tag, " out_valid"}, 64'(if8.out_valid), 64'(exp_vld));
    check({tag, " out_data"},  64'(if8.out_data),  64'(exp_data));
    check({tag, " out_chan"},  64'(if8.out_chan),  64'(exp_chan));
    @(negedge clk);
  endtask

  initial begin
    //          valid  sel   rr    ordy  data  rdy    vld   data   chan
    tbl[0]  = '{8'h20, 3'd5, 1'b0, 1'b1, D0, 8'h20, 1'b1, 8'hF1, 3'd5};
    tbl[1]  = '{8'h30, 3'd4, 1'b0, 1'b0, D0, 8'h00, 1'b1, 8'hF1, 3'd5};
    tbl[2]  = '{8'h30, 3'd3, 1'b0, 1'b0, D1, 8'h00, 1'b1, 8'hF1, 3'd5};
    tbl[3]  = '{8'h30, 3'd4, 1'b0, 1'b0, D0, 8'h00, 1'b1, 8'hF1, 3'd5};
    tbl[4]  = '{8'h30, 3'd4, 1'b0, 1'b1, D0, 8'h10, 1'b1, 8'hA4, 3'd4};
    tbl[5]  = '{8'h00, 3'd4, 1'b0, 1'b1, D0, 8'h10, 1'b0, 8'hA4, 3'd4};
    tbl[6]  = '{8'h00, 3'd2, 1'b0, 1'b0, D0, 8'h04, 1'b0, 8'hA4, 3'd4};
    tbl[7]  = '{8'h01, 3'd0, 1'b0, 1'b0, D0, 8'h01, 1'b1, 8'hA0, 3'd0};
    tbl[8]  = '{8'h80, 3'd7, 1'b0, 1'b1, D1, 8'h80, 1'b1, 8'h01, 3'd7};
    tbl[9]  = '{8'h80, 3'd7, 1'b0, 1'b0, D1, 8'h00, 1'b1, 8'h01, 3'd7};
    tbl[10] = '{8'h00, 3'd7, 1'b0, 1'b1, D1, 8'h80, 1'b0, 8'h01, 3'd7};

    // Clock/reset: in_ready must stay low while rst is high even with a granted valid channel.
    rst = 1'b1;
    drive8(8'h20, 3'd5, 1'b0, 1'b1, D0);
    if6.in_valid  = 6'h3F;
    if6.sel       = 3'd5;
    if6.rr_mode   = 1'b0;
    if6.out_ready = 1'b1;
    if6.in_data   = 48'h1514_1312_1110;
    @(posedge clk);
    @(negedge clk);
    check("reset in_ready8", 64'(if8.in_ready), 64'h0);
    check("reset in_ready6", 64'(if6.in_ready), 64'h0);
    check("reset out_valid", 64'(if8.out_valid), 64'h0);
    check("reset out_data",  64'(if8.out_data),  64'h0);
    check("reset out_chan",  64'(if8.out_chan),  64'h0);
    drive8(8'h00, 3'd0, 1'b0, 1'b1, D0);
    if6.sel = 3'd7;
    rst = 1'b0;

    // Out-of-range select on the 6-channel instance: no grant, output stays empty.
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("oor in_ready %0d", i), 64'(if6.in_ready), 64'h0);
      @(posedge clk);
      #1;
      check($sformatf("oor out_valid %0d", i), 64'(if6.out_valid), 64'h0);
      @(negedge clk);
    end
    if6.sel = 3'd5;
    #1;
    check("ch6 sel5 in_ready", 64'(if6.in_ready), 64'h20);
    @(posedge clk);
    #1;
    check("ch6 sel5 out_valid", 64'(if6.out_valid), 64'h1);
    check("ch6 sel5 out_data",  64'(if6.out_data),  64'h15);
    check("ch6 sel5 out_chan",  64'(if6.out_chan),  64'h5);
    @(negedge clk);
    if6.in_valid = 6'h00;

    // Fixed select, backpressure with sel/data changes, same-cycle reload, drain.
    for (int i = 0; i < 11; i++) begin
      drive8(tbl[i].valid, tbl[i].sel, tbl[i].rr, tbl[i].ordy, tbl[i].data);
      step($sformatf("vec%0d", i), tbl[i].exp_rdy, tbl[i].exp_vld, tbl[i].exp_data, tbl[i].exp_chan);
    end

    // Reset while FULL drops the word without an output handshake.
    drive8(8'h08, 3'd3, 1'b0, 1'b0, D0);
    step("load ch3", 8'h08, 1'b1, 8'hA3, 3'd3);
    rst = 1'b1;
    #1;
    check("midrst in_ready", 64'(if8.in_ready), 64'h0);
    @(posedge clk);
    #1;
    check("midrst out_valid", 64'(if8.out_valid), 64'h0);
    check("midrst out_data",  64'(if8.out_data),  64'h0);
    check("midrst out_chan",  64'(if8.out_chan),  64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive8(8'h00, 3'd3, 1'b0, 1'b1, DK);
    step("post rst idle", 8'h08, 1'b0, 8'h00, 3'd0);

`ifdef STREAM_MUX_RR_EN
    // All channels valid after reset: grants 0..7 then wrap to 0, one word per cycle.
    for (int i = 0; i < 9; i++) begin
      drive8(8'hFF, 3'd0, 1'b1, 1'b1, DK);
      step($sformatf("rr all %0d", i), 8'(1 << (i % 8)), 1'b1, 8'(i % 8), 3'(i % 8));
    end
    drive8(8'h40, 3'd0, 1'b1, 1'b1, DK);
    step("rr ptr to 6", 8'h40, 1'b1, 8'h06, 3'd6);
    for (int i = 0; i < 4; i++) begin
      drive8(8'h44, 3'd0, 1'b1, 1'b1, DK);
      step($sformatf("rr skip %0d", i), (i % 2 == 0) ? 8'h04 : 8'h40, 1'b1,
           (i % 2 == 0) ? 8'h02 : 8'h06, (i % 2 == 0) ? 3'd2 : 3'd6);
    end
    // A fixed-mode accept of channel 1 must not move ptr away from 6.
    drive8(8'h02, 3'd1, 1'b0, 1'b1, DK);
    step("fixed keeps ptr", 8'h02, 1'b1, 8'h01, 3'd1);
    drive8(8'h05, 3'd1, 1'b1, 1'b1, DK);
    step("rr after fixed", 8'h01, 1'b1, 8'h00, 3'd0);
    drive8(8'h00, 3'd1, 1'b1, 1'b1, DK);
    step("rr no request", 8'h00, 1'b0, 8'h00, 3'd0);
`else
    // rr_mode is ignored: sel still chooses, even when another channel is valid.
    drive8(8'h10, 3'd2, 1'b1, 1'b1, DK);
    step("rr ignored idle", 8'h04, 1'b0, 8'h00, 3'd0);
    drive8(8'h14, 3'd2, 1'b1, 1'b1, DK);
    step("rr ignored load", 8'h04, 1'b1, 8'h02, 3'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_mux_nx1.md
# stream_mux_nx1

Parametrised N:1 stream multiplexer with a registered output and valid/ready handshaking on every channel. It is the next generation of the team's 8:1 data-select mux: width and channel count are parameters, and selection is either a fixed `sel` index or round-robin arbitration. It sits between multiple producer streams and a single consumer, and provides one output register stage so that downstream stalls never corrupt held data.

## Interface
- `WIDTH`, 8: data width per channel.
- `CHANNELS`, 8: number of input channels, ≥2.
- `SEL_W`, localparam = $clog2(CHANNELS): index width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `in_data` in CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid` in CHANNELS: per-channel valid.
- `in_ready` out CHANNELS: per-channel ready; at most one bit set per cycle.
- `sel` in SEL_W: channel index used in fixed mode.
- `rr_mode` in 1: 1 selects round-robin, 0 selects fixed.
- `out_data` out WIDTH: registered output data.
- `out_valid` out 1: output register holds valid data.
- `out_ready` in 1: consumer accepts.
- `out_chan` out SEL_W: source channel index of `out_data`.

## Operation
- State is a 1-deep output register, EMPTY/FULL, reflected by `out_valid`.
- `load_ok` = !out_valid || out_ready. A transfer out happens when out_valid && out_ready.
- Grant g is computed combinationally each cycle:
  - Fixed mode: g = sel. If sel ≥ CHANNELS, there is no grant.
  - RR mode: g is the first k with in_valid[k], searching ptr+1, ptr+2, … modulo CHANNELS. If no channel is valid, there is no grant.
- in_ready[g] = load_ok. All other in_ready bits are 0. All in_ready bits are 0 while rst is high.
- An accept occurs when in_valid[g] && in_ready[g]. On accept:
  - out_data <= channel g data; out_chan <= g; out_valid <= 1.
  - RR mode only: ptr <= g.
- Transfer out without accept: out_valid <= 0, and out_data and out_chan hold.
- Transfer out with a simultaneous accept: the register is reloaded, giving full throughput of one word per cycle.
- Held data is frozen while FULL and !out_ready. Changes to sel, rr_mode or in_data do not alter it.
- Mode or sel changes take effect on the next accept decision. No data is lost or duplicated.
- ptr is updated only in RR mode. A fixed-mode accept leaves ptr unchanged.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, ptr=CHANNELS-1, so the first RR search starts at channel 0.
- Latency is 1 cycle from the accept edge to out_valid=1 with the data.
- in_ready has a combinational path from out_ready, out_valid, sel, rr_mode and (in RR mode) in_valid. There is no path from in_data.
- rst asserted mid-transfer drops the held word, with no out handshake. The output is empty on the cycle after rst deasserts.
- RR wrap-around: ptr=CHANNELS-1 searches from channel 0.
- RR fairness: a continuously valid channel waits at most CHANNELS-1 accepts.

## Configuration
- Macro `STREAM_MUX_RR_EN`.
- Defined: round-robin logic, ptr and the rr_mode behaviour are compiled in as described.
- Undefined: the rr_mode port still exists but is ignored, and fixed mode always applies. ptr and the search logic are absent. All other behaviour is unchanged.

## Structure
- Shared package `stream_mux_pkg` holds:
  - typedef enum logic {MODE_FIXED, MODE_RR} mode_e;
  - a function for the index width.
- One sub-module, `rr_arbiter`. Parameter CHANNELS; inputs req[CHANNELS] and ptr; outputs gnt_idx and gnt_any. It is purely combinational, with a rotate-priority search.
- The top level holds the output register, ptr and the ready/accept logic.

## Test plan
- Fixed select, CHANNELS=8, WIDTH=8: ch5=8'hF1 valid, sel=5, out_ready=1.
  - Expected: in_ready=8'b0010_0000; next cycle out_data=8'hF1, out_chan=5, out_valid=1.
- Backpressure: FULL with 8'hF1, out_ready=0 for 3 cycles, sel changed to 4.
  - Expected: out_data stays 8'hF1; in_ready=0; on out_ready=1, channel 4 loads in the same cycle.
- Round-robin: all 8 channels valid with data=k, out_ready=1, rr_mode=1.
  - Expected: out_chan sequence 0,1,…,7,0; one word per cycle.
- RR skip and wrap: only channels 2 and 6 valid, ptr=6.
  - Expected: grants 2,6,2,6.
- Out-of-range select: CHANNELS=6, sel=7, all valid.
  - Expected: in_ready=0 and out_valid stays 0.
- Reset mid-stream: rst=1 for 1 cycle while FULL.
  - Expected: next cycle out_valid=0, out_data=0, out_chan=0; the RR search restarts at channel 0.
